// File: rtl/tts_pkg.sv
// -----------------------------------------------------------------------------
// tts_pkg
// Shared definitions for the truth-table sweeper: FSM state encoding and the
// sweep-length helper used to size the vector counter's terminal value.
// -----------------------------------------------------------------------------
package tts_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Number of vectors in an exhaustive sweep of n inputs.
  function automatic int unsigned sweep_len(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_if
// Bundles the sweeper's control, stimulus and result signals.
//   master : harness side  - drives start, res_a, res_b; observes results
//   slave  : sweeper side  - drives vec and all result/status signals
// Signals:
//   start      request a sweep
//   res_a/b    outputs of the two implementations under comparison
//   vec        N_IN-bit stimulus vector
//   busy/done  sweep in progress / one-cycle completion pulse
//   pass, mism_cnt, first_bad, bad_vld  sweep results
// -----------------------------------------------------------------------------
interface truth_table_sweeper_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            res_a;
  logic            res_b;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   mism_cnt;
  logic [N_IN-1:0] first_bad;
  logic            bad_vld;

  modport master (
    output start, res_a, res_b,
    input  vec, busy, done, pass, mism_cnt, first_bad, bad_vld
  );

  modport slave (
    input  start, res_a, res_b,
    output vec, busy, done, pass, mism_cnt, first_bad, bad_vld
  );
endinterface

// File: rtl/tts_settle_timer.sv
// -----------------------------------------------------------------------------
// tts_settle_timer
// Counts the cycles a stimulus vector has been held. Cleared by i_load,
// advances while i_run, and stops at SETTLE-1 where o_expire is asserted.
// Ports:
//   i_clk     rising-edge clock
//   i_rst     synchronous active-high reset
//   i_load    clear the count to 0
//   i_run     advance the count (SETTLE state)
//   o_expire  count has reached SETTLE-1 while running
// -----------------------------------------------------------------------------
module tts_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expire
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_expire  = w_at_last & i_run;

  // Settle counter: clear on load, count up while running, hold at LAST.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_load) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_run && !w_at_last) begin
      r_cnt <= r_cnt + CW'(1'b1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Exhaustively sweeps an N_IN-bit vector through two implementations of the
// same function, comparing their outputs after a settle interval. Counts
// mismatching vectors, captures the lowest failing vector and reports pass.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset (aborts a sweep, no done pulse)
//   bus    slave side of truth_table_sweeper_if (start/res_a/res_b in,
//          vec/busy/done/pass/mism_cnt/first_bad/bad_vld out, all registered)
// -----------------------------------------------------------------------------
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  truth_table_sweeper_if.slave        bus
);

  localparam logic [N_IN-1:0] VEC_MAX = N_IN'(sweep_len(N_IN) - 32'd1);

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            w_expire;
  logic            w_last_vec;
  logic            w_mismatch;

  logic [N_IN-1:0] r_vec,       w_vec;
  logic            r_busy,      w_busy;
  logic            r_done,      w_done;
  logic            r_pass,      w_pass;
  logic [N_IN:0]   r_mism_cnt,  w_mism_cnt;
  logic [N_IN-1:0] r_first_bad, w_first_bad;
  logic            r_bad_vld,   w_bad_vld;

  assign w_last_vec = (r_vec == VEC_MAX);
  assign w_mismatch = bus.res_a ^ bus.res_b;

  tts_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (r_state != ST_SETTLE),
    .i_run    (r_state == ST_SETTLE),
    .o_expire (w_expire)
  );

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_SETTLE;
        else           w_state_nxt = ST_IDLE;
      end
      ST_SETTLE: begin
        if (w_expire) w_state_nxt = ST_CHECK;
        else          w_state_nxt = ST_SETTLE;
      end
      ST_CHECK: begin
        if (w_last_vec) w_state_nxt = ST_DONE;
        else            w_state_nxt = ST_SETTLE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; res_a/res_b are only looked at in CHECK.
  always_comb begin
    w_vec       = r_vec;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_pass      = r_pass;
    w_mism_cnt  = r_mism_cnt;
    w_first_bad = r_first_bad;
    w_bad_vld   = r_bad_vld;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_vec       = {N_IN{1'b0}};
          w_mism_cnt  = {(N_IN+1){1'b0}};
          w_bad_vld   = 1'b0;
          w_first_bad = {N_IN{1'b0}};
          w_pass      = 1'b0;
          w_busy      = 1'b1;
        end else begin
          w_busy      = 1'b0;
        end
      end
      ST_SETTLE: begin
        w_busy = 1'b1;
      end
      ST_CHECK: begin
        if (w_mismatch) begin
          w_mism_cnt = r_mism_cnt + {{N_IN{1'b0}}, 1'b1};
          if (!r_bad_vld) begin
            w_first_bad = r_vec;
            w_bad_vld   = 1'b1;
          end else begin
            w_first_bad = r_first_bad;
          end
        end else begin
          w_mism_cnt = r_mism_cnt;
        end
        // Pass is decided on the count including this final CHECK.
        if (w_last_vec) begin
          w_done = 1'b1;
          w_pass = (w_mism_cnt == {(N_IN+1){1'b0}});
        end else begin
          w_vec  = r_vec + {{(N_IN-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        w_busy = 1'b0;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vec       <= {N_IN{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_mism_cnt  <= {(N_IN+1){1'b0}};
      r_first_bad <= {N_IN{1'b0}};
      r_bad_vld   <= 1'b0;
    end else begin
      r_vec       <= w_vec;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_pass      <= w_pass;
      r_mism_cnt  <= w_mism_cnt;
      r_first_bad <= w_first_bad;
      r_bad_vld   <= w_bad_vld;
    end
  end

  assign bus.vec       = r_vec;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.mism_cnt  = r_mism_cnt;
  assign bus.first_bad = r_first_bad;
  assign bus.bad_vld   = r_bad_vld;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Directed bench for truth_table_sweeper: a 2-input/SETTLE=1 instance with
// selectable implementation A, and a 3-input/SETTLE=3 instance.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

  logic clk;
  logic rst;
  logic [1:0] mode;
  int n_assert;
  int n_fail;
  logic [31:0] vec_log [0:127];

  truth_table_sweeper_if #(.N_IN(2)) bus2 ();
  truth_table_sweeper_if #(.N_IN(3)) bus3 ();

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) u_dut2 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus2)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) u_dut3 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus3)
  );

  // a & ~b: behavioural for B, NOR form ~(~a | b) for A; mode plants faults in A
  assign bus2.res_b = bus2.vec[1] & ~bus2.vec[0];
  assign bus2.res_a = (mode == 2'd0) ? ~(~bus2.vec[1] | bus2.vec[0]) :
                      (mode == 2'd1) ? ~(bus2.vec[1] | bus2.vec[0]) :
                                       ~(bus2.vec[1] & ~bus2.vec[0]);
  assign bus3.res_b = bus3.vec[1] & ~bus3.vec[0];
  assign bus3.res_a = ~(~bus3.vec[1] | bus3.vec[0]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cur_vec(input bit sel);
    return sel ? 32'(bus3.vec) : 32'(bus2.vec);
  endfunction

  function automatic logic cur_done(input bit sel);
    return sel ? bus3.done : bus2.done;
  endfunction

  // Pulse start for one edge, then return the cycle in which done is seen (-1 on timeout).
  task automatic run_sweep(input bit sel, output int lat);
    int cyc;
    if (sel) bus3.start = 1'b1; else bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    bus3.start = 1'b0;
    cyc = 1;
    vec_log[1] = cur_vec(sel);
    lat = -1;
    while (lat < 0 && cyc < 100) begin
      if (cur_done(sel)) begin
        lat = cyc;
      end else begin
        tick();
        cyc++;
        vec_log[cyc] = cur_vec(sel);
      end
    end
  endtask

  initial begin
    int lat;
    int cyc;
    int seen;
    n_assert   = 0;
    n_fail     = 0;
    mode       = 2'd0;
    rst        = 1'b1;
    bus2.start = 1'b0;
    bus3.start = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_vec",       32'(bus2.vec),       32'd0);
    chk("rst_busy",      32'(bus2.busy),      32'd0);
    chk("rst_done",      32'(bus2.done),      32'd0);
    chk("rst_pass",      32'(bus2.pass),      32'd0);
    chk("rst_mism",      32'(bus2.mism_cnt),  32'd0);
    chk("rst_first_bad", 32'(bus2.first_bad), 32'd0);
    chk("rst_bad_vld",   32'(bus2.bad_vld),   32'd0);
    chk("rst3_busy",     32'(bus3.busy),      32'd0);
    rst = 1'b0;
    tick();

    // 1. Equivalent implementations
    mode = 2'd0;
    run_sweep(1'b0, lat);
    chk("t1_latency", 32'(lat), 32'd9);
    chk("t1_vec_c1",  vec_log[1], 32'd0);
    chk("t1_vec_c3",  vec_log[3], 32'd1);
    chk("t1_vec_c5",  vec_log[5], 32'd2);
    chk("t1_vec_c8",  vec_log[8], 32'd3);
    chk("t1_busy_done", 32'(bus2.busy),    32'd1);
    chk("t1_mism",    32'(bus2.mism_cnt),  32'd0);
    chk("t1_pass",    32'(bus2.pass),      32'd1);
    chk("t1_bad_vld", 32'(bus2.bad_vld),   32'd0);
    tick();
    chk("t1_done_pulse", 32'(bus2.done), 32'd0);
    chk("t1_busy_idle",  32'(bus2.busy), 32'd0);
    chk("t1_vec_hold",   32'(bus2.vec),  32'd3);
    chk("t1_pass_hold",  32'(bus2.pass), 32'd1);

    // 2. Faulty A: mismatches at vectors 0 and 2
    mode = 2'd1;
    run_sweep(1'b0, lat);
    chk("t2_latency",   32'(lat),            32'd9);
    chk("t2_mism",      32'(bus2.mism_cnt),  32'd2);
    chk("t2_first_bad", 32'(bus2.first_bad), 32'd0);
    chk("t2_bad_vld",   32'(bus2.bad_vld),   32'd1);
    chk("t2_pass",      32'(bus2.pass),      32'd0);
    tick();

    // 3. Total inversion: count reaches 2^N_IN without overflow
    mode = 2'd2;
    run_sweep(1'b0, lat);
    chk("t3_mism",      32'(bus2.mism_cnt),  32'd4);
    chk("t3_first_bad", 32'(bus2.first_bad), 32'd0);
    chk("t3_bad_vld",   32'(bus2.bad_vld),   32'd1);
    chk("t3_pass",      32'(bus2.pass),      32'd0);
    tick();

    // 4. Reset during a sweep
    mode = 2'd2;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_vec_c4",  32'(bus2.vec),      32'd1);
    chk("t4_mism_c4", 32'(bus2.mism_cnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_busy",    32'(bus2.busy),     32'd0);
    chk("t4_vec",     32'(bus2.vec),      32'd0);
    chk("t4_mism",    32'(bus2.mism_cnt), 32'd0);
    chk("t4_bad_vld", 32'(bus2.bad_vld),  32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus2.done) seen++;
      tick();
    end
    chk("t4_no_done", 32'(seen), 32'd0);
    mode = 2'd0;
    run_sweep(1'b0, lat);
    chk("t4_restart_latency", 32'(lat), 32'd9);
    chk("t4_restart_pass", 32'(bus2.pass), 32'd1);
    tick();

    // 5. Start pulses mid-sweep and in DONE are ignored
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    tick();
    tick();
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    chk("t5_vec_c4", 32'(bus2.vec), 32'd1);
    for (int c = 5; c <= 9; c++) tick();
    chk("t5_done_c9", 32'(bus2.done), 32'd1);
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    chk("t5_busy_c10", 32'(bus2.busy), 32'd0);
    tick();
    chk("t5_busy_c11", 32'(bus2.busy), 32'd0);
    tick();

    // 5b. Start held high relaunches right after returning to IDLE
    bus2.start = 1'b1;
    tick();
    cyc = 1;
    while (!bus2.done && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("t5_held_latency", 32'(cyc), 32'd9);
    tick();
    chk("t5_held_idle_busy", 32'(bus2.busy), 32'd0);
    tick();
    bus2.start = 1'b0;
    chk("t5_held_relaunch_busy", 32'(bus2.busy), 32'd1);
    chk("t5_held_relaunch_vec",  32'(bus2.vec),  32'd0);
    cyc = 11;
    while (!bus2.done && cyc < 80) begin
      tick();
      cyc++;
    end
    chk("t5_held_second_done", 32'(cyc), 32'd19);
    tick();

    // 6. N_IN=3, SETTLE=3, equivalent implementations
    run_sweep(1'b1, lat);
    chk("t6_latency",  32'(lat), 32'd33);
    chk("t6_vec_c3",   vec_log[3],  32'd0);
    chk("t6_vec_c4",   vec_log[4],  32'd0);
    chk("t6_vec_c5",   vec_log[5],  32'd1);
    chk("t6_vec_c29",  vec_log[29], 32'd7);
    chk("t6_mism",     32'(bus3.mism_cnt), 32'd0);
    chk("t6_pass",     32'(bus3.pass),     32'd1);
    tick();
    chk("t6_vec_hold", 32'(bus3.vec), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
